// File: rtl/snake_pkg.sv
// snake_pkg: shared direction codes, FSM state codes and board defaults for the snake head logic
package snake_pkg;
  localparam logic [1:0] DIR_UP = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_LEFT = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;
  localparam int GRID_W_DEF = 32;
  localparam int GRID_H_DEF = 24;
  function automatic logic [1:0] reverse(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction
endpackage

// File: rtl/dir_fifo.sv
// dir_fifo: QDEPTH x 2-bit request queue, entry 0 is the oldest; same-cycle push+pop supported
module dir_fifo #(
  parameter int QDEPTH = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic [1:0] last,
  output logic       empty,
  output logic       full
);
  localparam int CW = $clog2(QDEPTH + 1);
  logic [1:0] mem [QDEPTH];
  logic [1:0] mem_n [QDEPTH];
  logic [CW-1:0] cnt, cnt_n;
  assign dout = mem[0];
  assign empty = cnt == '0;
  assign full = int'(cnt) == QDEPTH;
  always_comb begin
    last = mem[0];
    for (int i = 0; i < QDEPTH; i++) if (int'(cnt) == i + 1) last = mem[i];
  end
  // pop shifts first so a push in the same cycle lands behind the remaining entries
  always_comb begin
    mem_n = mem;
    cnt_n = cnt;
    if (pop && !empty) begin
      for (int i = 0; i < QDEPTH - 1; i++) mem_n[i] = mem[i + 1];
      cnt_n = cnt - 1'b1;
    end
    if (push && int'(cnt_n) < QDEPTH) begin
      for (int i = 0; i < QDEPTH; i++) if (i == int'(cnt_n)) mem_n[i] = din;
      cnt_n = cnt_n + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem <= '{default: 2'b00};
      cnt <= '0;
    end else begin
      mem <= mem_n;
      cnt <= flush ? '0 : cnt_n;
    end
  end
endmodule

// File: rtl/snake_head_stepper.sv
// snake_head_stepper: moves the snake head one cell per game tick, queues turns, detects wall hits
module snake_head_stepper
  import snake_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int START_X = 4,
  parameter int START_Y = 12,
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      tick,
  input  logic                      start,
  input  logic                      dir_valid,
  input  logic [1:0]                dir_in,
  output logic [$clog2(GRID_W)-1:0] head_x,
  output logic [$clog2(GRID_H)-1:0] head_y,
  output logic [1:0]                dir_cur,
  output logic                      step,
  output logic                      wall_hit,
  output logic                      running
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  logic [1:0] state, fifo_dout, fifo_last, d_req, d_next;
  logic fifo_empty, fifo_full, run, push, pop, flush, hit;
  logic [XW:0] nx;
  logic [YW:0] ny;
  assign run = state == ST_RUN;
  assign pop = run && tick && !fifo_empty;
  assign push = run && dir_valid && dir_in != (fifo_empty ? dir_cur : fifo_last) && (!fifo_full || pop);
  assign flush = !run && start;
  assign d_req = fifo_empty ? dir_cur : fifo_dout;
  assign d_next = d_req == reverse(dir_cur) ? dir_cur : d_req;
  // one extra bit makes -1 wrap to a large value, so one compare catches both edges
  assign nx = d_next == DIR_RIGHT ? {1'b0, head_x} + 1'b1 : d_next == DIR_LEFT ? {1'b0, head_x} - 1'b1 : {1'b0, head_x};
  assign ny = d_next == DIR_DOWN ? {1'b0, head_y} + 1'b1 : d_next == DIR_UP ? {1'b0, head_y} - 1'b1 : {1'b0, head_y};
  assign hit = nx >= (XW + 1)'(GRID_W) || ny >= (YW + 1)'(GRID_H);
  dir_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk(clk), .resetn(resetn), .push(push), .pop(pop), .flush(flush), .din(dir_in),
    .dout(fifo_dout), .last(fifo_last), .empty(fifo_empty), .full(fifo_full)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      head_x <= XW'(START_X);
      head_y <= YW'(START_Y);
      dir_cur <= DIR_RIGHT;
      step <= 1'b0;
      wall_hit <= 1'b0;
      running <= 1'b0;
    end else begin
      step <= 1'b0;
      wall_hit <= 1'b0;
      if (!run) begin
        if (start) begin
          state <= ST_RUN;
          head_x <= XW'(START_X);
          head_y <= YW'(START_Y);
          dir_cur <= DIR_RIGHT;
          running <= 1'b1;
        end
      end else if (tick) begin
        if (hit) begin
          state <= ST_DEAD;
          wall_hit <= 1'b1;
          running <= 1'b0;
        end else begin
          head_x <= nx[XW-1:0];
          head_y <= ny[YW-1:0];
          dir_cur <= d_next;
          step <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_snake_head_stepper.sv
// tb_snake_head_stepper: directed scenarios plus random play against a queue-based game model
module tb_snake_head_stepper;
  localparam int QD = 2;
  logic clk = 1'b0, resetn = 1'b0, tick = 1'b0, start = 1'b0, dir_valid = 1'b0;
  logic [1:0] dir_in = 2'b00;
  logic [4:0] head_x, head_y;
  logic [1:0] dir_cur;
  logic step, wall_hit, running;
  int n_cmp = 0, n_bad = 0;
  int mx, my, mdir, mode;
  bit mstep, mhit;
  int q[$];
  always #5 clk = ~clk;
  snake_head_stepper #(.GRID_W(32), .GRID_H(24), .START_X(4), .START_Y(12), .QDEPTH(QD)) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .start(start), .dir_valid(dir_valid), .dir_in(dir_in),
    .head_x(head_x), .head_y(head_y), .dir_cur(dir_cur), .step(step), .wall_hit(wall_hit), .running(running)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    mode = 0; mx = 4; my = 12; mdir = 1; mstep = 0; mhit = 0;
    q.delete();
  endtask
  // mode: 0 idle, 1 playing, 2 game over
  task automatic model_step(input bit t, input bit s, input bit v, input int d);
    int newest, nd, cx, cy;
    bit popping, accept;
    mstep = 0; mhit = 0;
    if (mode != 1) begin
      if (s) begin
        mode = 1; mx = 4; my = 12; mdir = 1;
        q.delete();
      end
      return;
    end
    newest = q.size() > 0 ? q[$] : mdir;
    popping = t && q.size() > 0;
    accept = v && d != newest && (q.size() < QD || popping);
    if (t) begin
      nd = popping ? q.pop_front() : mdir;
      if (nd == (mdir ^ 2)) nd = mdir;
      cx = mx + (nd == 1 ? 1 : 0) - (nd == 3 ? 1 : 0);
      cy = my + (nd == 2 ? 1 : 0) - (nd == 0 ? 1 : 0);
      if (cx < 0 || cx >= 32 || cy < 0 || cy >= 24) begin
        mhit = 1; mode = 2;
      end else begin
        mx = cx; my = cy; mdir = nd; mstep = 1;
      end
    end
    if (accept) q.push_back(d);
  endtask
  task automatic check_all(input string tag);
    check({tag, ".x"}, head_x, mx);
    check({tag, ".y"}, head_y, my);
    check({tag, ".dir"}, dir_cur, mdir);
    check({tag, ".step"}, step, mstep);
    check({tag, ".hit"}, wall_hit, mhit);
    check({tag, ".run"}, running, mode == 1);
  endtask
  task automatic cyc(input bit t, input bit s, input bit v, input int d);
    tick = t; start = s; dir_valid = v; dir_in = 2'(d);
    @(posedge clk);
    model_step(t, s, v, d);
    @(negedge clk);
    tick = 0; start = 0; dir_valid = 0;
    check_all("cyc");
  endtask
  task automatic do_reset();
    resetn = 0;
    #1;
    model_reset();
    check_all("rst");
    #2 resetn = 1;
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    check_all("por");
    resetn = 1;
    cyc(0, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    check("t1_x", head_x, 7);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 3);
    cyc(1, 0, 0, 0);
    check("t2_y", head_y, 11);
    check("t2_dir", dir_cur, 0);
    cyc(1, 0, 0, 0);
    check("t2_x", head_x, 6);
    check("t2_dir2", dir_cur, 3);
    cyc(0, 0, 1, 1);
    cyc(1, 0, 0, 0);
    check("t3_x", head_x, 5);
    cyc(1, 0, 0, 0);
    check("t3_empty", head_y, 11);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 3);
    cyc(0, 0, 1, 2);
    cyc(1, 0, 0, 0);
    check("t4_up", head_y, 10);
    cyc(1, 0, 0, 0);
    check("t4_left", head_x, 3);
    cyc(1, 0, 0, 0);
    check("t4_drop", head_y, 10);
    repeat (3) cyc(1, 0, 0, 0);
    check("t5_lhit", mode, 2);
    cyc(0, 1, 0, 0);
    repeat (27) cyc(1, 0, 0, 0);
    check("t5_x31", head_x, 31);
    cyc(1, 0, 0, 0);
    check("t5_hit", wall_hit, 1);
    check("t5_stay", head_x, 31);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("t5_frozen", head_x, 31);
    cyc(1, 1, 0, 0);
    check("t5_restart", head_x, 4);
    cyc(0, 0, 1, 0);
    do_reset();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check("t6_x", head_x, 5);
    check("t6_y", head_y, 12);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
